// File: rtl/rsa_uart_tx_buffer_pkg.sv
// Shared types and constants for the RSA result UART transmit buffer.
package rsa_uart_tx_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_t;

  localparam int unsigned UartDataBits      = 8;
  localparam int unsigned DefaultClksPerBit = 434;
  localparam int unsigned DefaultFifoDepth  = 16;

endpackage

// File: rtl/rsa_uart_tx_buffer_byte_fifo.sv
// Circular byte FIFO; head entry is presented on dout whenever the FIFO is non-empty.
module rsa_uart_tx_buffer_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en, rd_en;

  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    empty    = (count_q == '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    wr_en    = push & (~full | pop);
    rd_en    = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rsa_uart_tx_buffer.sv
// Captures CPU read-data bytes on strobe rising edges, queues them and sends them as UART 8N1.
module rsa_uart_tx_buffer
  import rsa_uart_tx_buffer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned FIFO_DEPTH   = DefaultFifoDepth,
  parameter int unsigned DATA_W       = UartDataBits
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_strobe,
  input  logic [DATA_W-1:0]           byte_in,
  input  logic                        end_flag,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        done
);

  localparam int unsigned CtrW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [CtrW-1:0] CtrMax  = CtrW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  uart_state_t       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CtrW-1:0]   ctr_q, ctr_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              rd_strobe_q, rd_strobe_d;
  logic              end_seen_q, end_seen_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  logic              push, pop, full, empty;
  logic [DATA_W-1:0] fifo_dout;

  assign push = rd_strobe & ~rd_strobe_q;
  assign pop  = (state_q == StIdle) & ~empty;

  rsa_uart_tx_buffer_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (byte_in),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    ctr_d       = ctr_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    rd_strobe_d = rd_strobe;
    end_seen_d  = end_seen_q | end_flag;
    overflow_d  = overflow_q | (push & full & ~pop);
    done_d      = done_q | (end_seen_q & empty & (state_q == StIdle));

    case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d   = StStart;
          shift_d   = fifo_dout;
          ctr_d     = '0;
          bit_idx_d = '0;
          tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (ctr_q == CtrMax) begin
          state_d = StData;
          ctr_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      StData: begin
        if (ctr_q == CtrMax) begin
          ctr_d = '0;
          if (bit_idx_q == IdxLast) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_d[0];
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      StStop: begin
        if (ctr_q == CtrMax) begin
          state_d = StIdle;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      ctr_q       <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      rd_strobe_q <= 1'b0;
      end_seen_q  <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      ctr_q       <= ctr_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      rd_strobe_q <= rd_strobe_d;
      end_seen_q  <= end_seen_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle) | ~empty;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rsa_uart_tx_buffer.sv
// Bench for rsa_uart_tx_buffer: queue/frame-table model, line receiver and directed scenarios.
module tb_rsa_uart_tx_buffer;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 4;

  logic       clk, reset, rd_strobe, end_flag;
  logic [7:0] byte_in;
  logic       tx, busy, overflow, done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  rsa_uart_tx_buffer #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (Depth),
    .DATA_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_strobe  (rd_strobe),
    .byte_in    (byte_in),
    .end_flag   (end_flag),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the position inside the frame on the wire.
  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  logic [7:0] m_cur = 8'h00;
  int         m_t = 0;
  logic       m_end_seen = 1'b0, m_done = 1'b0, m_ovf = 1'b0, m_prev = 1'b0;
  logic       model_ok = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / Cpb;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_active = 1'b0; m_t = 0; m_end_seen = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
        m_prev = 1'b0; model_ok = 1'b1;
      end else begin
        logic push, pop, done_nx;
        int   sz;
        sz      = m_q.size();
        push    = rd_strobe & ~m_prev;
        pop     = !m_active && sz > 0;
        done_nx = m_done | (m_end_seen && sz == 0 && !m_active);
        if (m_active) begin
          m_t++;
          if (m_t == 10 * Cpb) m_active = 1'b0;
        end
        if (pop) begin
          m_cur = m_q.pop_front();
          m_active = 1'b1;
          m_t = 0;
        end
        if (push) begin
          if (sz < Depth || pop) m_q.push_back(byte_in);
          else m_ovf = 1'b1;
        end
        m_done = done_nx;
        m_end_seen = m_end_seen | end_flag;
        m_prev = rd_strobe;
      end
      @(negedge clk);
      if (model_ok) begin
        check("tx", tx, m_active ? frame_bit(m_cur, m_t) : 1'b1);
        check("busy", busy, m_active || m_q.size() > 0);
        check("fifo_count", fifo_count, m_q.size());
        check("overflow", overflow, m_ovf);
        check("done", done, m_done);
      end
    end
  end

  // Line receiver: decodes frames from tx, sampling once per bit period.
  logic [7:0] rx_q[$];
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          b[i] = tx;
        end
        repeat (Cpb) @(negedge clk);
        rx_q.push_back(b);
      end
      prev = tx;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    byte_in   = b;
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_rx(input string name, input int n, input logic [7:0] first);
    check(name, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) check(name, rx_q[i], first + 8'(i));
  endtask

  initial begin
    int bc, peak;
    reset = 1'b1; rd_strobe = 1'b0; byte_in = 8'h00; end_flag = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte: A5 goes low two cycles after the strobe, busy for 40 cycles from then.
    push_byte(8'hA5);
    check("t1_count", fifo_count, 1);
    check("t1_tx_idle", tx, 1'b1);
    @(negedge clk);
    check("t1_tx_start", tx, 1'b0);
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check("t1_busy_cycles", bc, 40);
    check_rx("t1_rx", 1, 8'hA5);

    // Held strobe yields one frame.
    rx_q.delete();
    byte_in = 8'h3C; rd_strobe = 1'b1; peak = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_count > peak) peak = fifo_count;
    end
    rd_strobe = 1'b0;
    while (busy === 1'b1 && bc < 400) begin
      bc++;
      @(negedge clk);
      if (fifo_count > peak) peak = fifo_count;
    end
    wait_idle("t2_idle");
    check("t2_peak", peak, 1);
    check_rx("t2_rx", 1, 8'h3C);

    // Burst of six: fifth fills the FIFO, sixth is dropped.
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      push_byte(8'(i));
      @(negedge clk);
    end
    check("t3_overflow", overflow, 1'b1);
    check("t3_count", fifo_count, 4);
    wait_idle("t3_idle");
    check_rx("t3_rx", 5, 8'h01);

    // Full FIFO, push lands on the IDLE pop cycle.
    apply_reset();
    push_byte(8'h10);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      push_byte(8'h10 + 8'(i));
    end
    repeat (33) @(negedge clk);
    check("t4_count_before", fifo_count, 4);
    push_byte(8'h15);
    check("t4_count_after", fifo_count, 4);
    check("t4_overflow", overflow, 1'b0);
    wait_idle("t4_idle");
    check_rx("t4_rx", 6, 8'h10);

    // End flag pulsed during the second of three frames.
    apply_reset();
    push_byte(8'h21);
    @(negedge clk); push_byte(8'h22);
    @(negedge clk); push_byte(8'h23);
    repeat (55) @(negedge clk);
    end_flag = 1'b1;
    @(negedge clk);
    end_flag = 1'b0;
    check("t5_done_mid", done, 1'b0);
    wait_idle("t5_idle");
    check("t5_done_at_idle", done, 1'b0);
    @(negedge clk);
    check("t5_done_set", done, 1'b1);
    push_byte(8'h24);
    repeat (3) @(negedge clk);
    check("t5_busy_late", busy, 1'b1);
    check("t5_done_late", done, 1'b1);
    wait_idle("t5_idle2");
    check("t5_done_final", done, 1'b1);
    check_rx("t5_rx", 4, 8'h21);

    // Reset during data bit 3 with overflow set.
    apply_reset();
    push_byte(8'h5A);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      push_byte(8'hB0 + 8'(i));
    end
    check("t6_overflow_pre", overflow, 1'b1);
    check("t6_count_pre", fifo_count, 4);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_tx", tx, 1'b1);
    check("t6_count", fifo_count, 0);
    check("t6_overflow", overflow, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_busy", busy, 1'b0);
    repeat (12 * Cpb) @(negedge clk);
    rx_q.delete();
    push_byte(8'h77);
    wait_idle("t6_idle");
    check_rx("t6_rx", 1, 8'h77);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
